// File: rtl/frag_minhash.sv
// MinHash signature generator: per-lane multiply-add hashes over a stream of
// 2-bit-per-base fragments, one signature (lane minima + fragment count) per window.
module frag_minhash #(
   parameter int                   FRAG_LEN  = 16,
   parameter int                   HASH_BITS = 16,
   parameter int                   NUM_HASH  = 4,
   parameter logic [HASH_BITS-1:0] MULT_BASE = 16'h9E37,
   parameter int                   MULT_STEP = 2,
   parameter logic [HASH_BITS-1:0] SEED_BASE = 16'h1234,
   parameter logic [HASH_BITS-1:0] SEED_STEP = 16'h0101,
   parameter int                   CNT_BITS  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [FRAG_LEN-1:0]           in_frag,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic                          sig_valid,
   output logic [NUM_HASH*HASH_BITS-1:0] sig_data,
   output logic [CNT_BITS-1:0]           sig_count,
   input  logic                          sig_ready,
   output logic                          busy
);

   logic                                en;
   logic                                s1_valid_reg;
   logic                                s1_last_reg;
   logic [FRAG_LEN-1:0]                 s1_frag_reg;
   logic [HASH_BITS-1:0]                x;
   logic [NUM_HASH-1:0][HASH_BITS-1:0]  hash;
   logic [NUM_HASH-1:0][HASH_BITS-1:0]  min_reg;
   logic [NUM_HASH-1:0][HASH_BITS-1:0]  min_next;
   logic [NUM_HASH-1:0][HASH_BITS-1:0]  sig_data_reg;
   logic [CNT_BITS-1:0]                 count_reg;
   logic [CNT_BITS-1:0]                 count_next;
   logic [CNT_BITS-1:0]                 sig_count_reg;
   logic                                sig_valid_reg;

   // A pending signature that nobody takes freezes the whole pipeline.
   assign en       = ~sig_valid_reg | sig_ready;
   assign in_ready = en;

   generate
      if (FRAG_LEN >= HASH_BITS) begin : g_x_trunc
         assign x = s1_frag_reg[HASH_BITS-1:0];
      end else begin : g_x_ext
         assign x = {{(HASH_BITS-FRAG_LEN){1'b0}}, s1_frag_reg};
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < NUM_HASH; gi++) begin : g_lane
         localparam logic [HASH_BITS-1:0] MULT_I = MULT_BASE + HASH_BITS'(gi * MULT_STEP);
         localparam logic [HASH_BITS-1:0] SEED_I = SEED_BASE + HASH_BITS'(gi) * SEED_STEP;

         // Low half of the full product is all that survives the modulus.
         assign hash[gi]     = x * MULT_I + SEED_I;
         // Strict less-than: a tie keeps the existing minimum.
         assign min_next[gi] = (hash[gi] < min_reg[gi]) ? hash[gi] : min_reg[gi];
      end
   endgenerate

   assign count_next = (count_reg == {CNT_BITS{1'b1}}) ? count_reg : count_reg + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         s1_frag_reg   <= '0;
         min_reg       <= '1;
         count_reg     <= '0;
         sig_data_reg  <= '0;
         sig_count_reg <= '0;
         sig_valid_reg <= 1'b0;
      end else if (en) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_frag_reg <= in_frag;
            s1_last_reg <= in_last;
         end
         // With en high any pending signature is being taken, so sig_valid
         // simply follows whether a window closes this cycle.
         sig_valid_reg <= s1_valid_reg & s1_last_reg;
         if (s1_valid_reg) begin
            if (s1_last_reg) begin
               sig_data_reg  <= min_next;
               sig_count_reg <= count_next;
               min_reg       <= '1;
               count_reg     <= '0;
            end else begin
               min_reg   <= min_next;
               count_reg <= count_next;
            end
         end
      end
   end

   assign sig_valid = sig_valid_reg;
   assign sig_data  = sig_data_reg;
   assign sig_count = sig_count_reg;
   assign busy      = s1_valid_reg | (count_reg != '0) | sig_valid_reg;

endmodule

// File: tb/tb_frag_minhash.sv
// Directed bench for frag_minhash: a default 4-lane instance and a 1-lane
// instance with a 2-bit counter share the same stimulus.
module tb_frag_minhash;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_frag;
   logic        in_last;
   logic        sig_ready;

   logic        in_ready;
   logic        sig_valid;
   logic [63:0] sig_data;
   logic [15:0] sig_count;
   logic        busy;

   logic        in_ready1;
   logic        sig_valid1;
   logic [15:0] sig_data1;
   logic [1:0]  sig_count1;
   logic        busy1;

   int n_vec = 0;
   int n_err = 0;

   frag_minhash dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_frag   (in_frag),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .sig_valid (sig_valid),
      .sig_data  (sig_data),
      .sig_count (sig_count),
      .sig_ready (sig_ready),
      .busy      (busy)
   );

   frag_minhash #(.NUM_HASH(1), .CNT_BITS(2)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_frag   (in_frag),
      .in_last   (in_last),
      .in_ready  (in_ready1),
      .sig_valid (sig_valid1),
      .sig_data  (sig_data1),
      .sig_count (sig_count1),
      .sig_ready (sig_ready),
      .busy      (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] f, input logic l);
      in_valid = 1'b1;
      in_frag  = f;
      in_last  = l;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_frag  = 16'h0000;
      in_last  = 1'b0;
      tick();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_frag   = 16'h0000;
      in_last   = 1'b0;
      sig_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_sig_valid", 64'(sig_valid), 64'd0);
      chk("rst_sig_data",  sig_data,       64'd0);
      chk("rst_sig_count", 64'(sig_count), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Window {0x0001, 0x0000+last}
      send(16'h0001, 1'b0);
      send(16'h0000, 1'b1);
      chk("w1_not_yet", 64'(sig_valid), 64'd0);
      idle();
      chk("w1_valid",   64'(sig_valid1), 64'd1);
      chk("w1_lane0",   64'(sig_data1),  64'h1234);
      chk("w1_count1",  64'(sig_count1), 64'd2);
      chk("w1_data4",   sig_data,        64'h1537_1436_1335_1234);
      chk("w1_count4",  64'(sig_count),  64'd2);
      idle();
      chk("w1_one_cycle", 64'(sig_valid), 64'd0);
      chk("w1_busy_done", 64'(busy),      64'd0);

      // Lone last fragment 0x0000
      send(16'h0000, 1'b1);
      idle();
      chk("w2_data",  sig_data,       64'h1537_1436_1335_1234);
      chk("w2_count", 64'(sig_count), 64'd1);
      idle();

      // Window {0x0002, 0x0001+last}
      send(16'h0002, 1'b0);
      send(16'h0001, 1'b1);
      idle();
      chk("w3_data",  sig_data,       64'h51B1_50AC_4FA7_4EA2);
      chk("w3_count", 64'(sig_count), 64'd2);
      idle();

      // Window {0x0002, 0x0002+last}: tie keeps the minimum
      send(16'h0002, 1'b0);
      send(16'h0002, 1'b1);
      idle();
      chk("w4_tie_data",  sig_data,       64'h51B1_50AC_4FA7_4EA2);
      chk("w4_tie_count", 64'(sig_count), 64'd2);
      idle();

      // Backpressure: window {3, 4+last} then {2, 3+last} streamed back to back
      sig_ready = 1'b0;
      send(16'h0003, 1'b0);
      send(16'h0004, 1'b1);
      send(16'h0002, 1'b0);
      chk("bp_valid", 64'(sig_valid), 64'd1);
      chk("bp_data",  sig_data,       64'h8E2B_8D22_8C19_8B10);
      chk("bp_count", 64'(sig_count), 64'd2);
      in_valid = 1'b1;
      in_frag  = 16'h0003;
      in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_in_ready_low", 64'(in_ready),  64'd0);
         chk("bp_hold_valid",   64'(sig_valid), 64'd1);
         chk("bp_hold_data",    sig_data,       64'h8E2B_8D22_8C19_8B10);
         chk("bp_hold_count",   64'(sig_count), 64'd2);
      end
      sig_ready = 1'b1;
      #1;
      chk("bp_in_ready_rel", 64'(in_ready), 64'd1);
      tick();
      chk("bp_taken", 64'(sig_valid), 64'd0);
      idle();
      chk("bp_next_valid", 64'(sig_valid), 64'd1);
      chk("bp_next_data",  sig_data,       64'h51B1_50AC_4FA7_4EA2);
      chk("bp_next_count", 64'(sig_count), 64'd2);
      idle();

      // Back-to-back one-fragment windows
      send(16'h0001, 1'b1);
      send(16'h0002, 1'b1);
      chk("b2b_x1", sig_data, 64'hB374_B271_B16E_B06B);
      send(16'h0003, 1'b1);
      chk("b2b_x2", sig_data, 64'h51B1_50AC_4FA7_4EA2);
      chk("b2b_v2", 64'(sig_valid), 64'd1);
      send(16'h0004, 1'b1);
      chk("b2b_x3", sig_data, 64'hEFEE_EEE7_EDE0_ECD9);
      chk("b2b_v3", 64'(sig_valid), 64'd1);
      idle();
      chk("b2b_x4", sig_data, 64'h8E2B_8D22_8C19_8B10);
      chk("b2b_c4", 64'(sig_count), 64'd1);
      idle();
      chk("b2b_end_valid", 64'(sig_valid), 64'd0);

      // Reset mid-window
      send(16'h0001, 1'b0);
      send(16'h0002, 1'b0);
      send(16'h0003, 1'b0);
      in_valid = 1'b0;
      chk("mr_busy_open", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy_rst",  64'(busy),      64'd0);
      chk("mr_valid_rst", 64'(sig_valid), 64'd0);
      chk("mr_ready_rst", 64'(in_ready),  64'd1);
      tick();
      rst_n = 1'b1;
      send(16'hFFFF, 1'b1);
      idle();
      chk("mr_data",   sig_data,        64'h76FA_75FB_74FC_73FD);
      chk("mr_count",  64'(sig_count),  64'd1);
      chk("mr_lane0",  64'(sig_data1),  64'h73FD);
      idle();

      // Counter saturation on the 2-bit instance; minima keep updating
      send(16'h0003, 1'b0);
      send(16'h0004, 1'b0);
      send(16'h0001, 1'b0);
      send(16'h0003, 1'b0);
      send(16'h0002, 1'b1);
      idle();
      chk("sat_count1", 64'(sig_count1), 64'd3);
      chk("sat_lane0",  64'(sig_data1),  64'h4EA2);
      chk("sat_count4", 64'(sig_count),  64'd5);
      chk("sat_data4",  sig_data,        64'h51B1_50AC_4FA7_4EA2);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
